// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
//   state_t     : sequencer state (IDLE / ISSUE / WAIT)
//   P0, P1      : port identifiers as carried on grant / pointer signals
//   TIMEOUT_DEF : default watchdog limit in WAIT cycles
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  localparam int TIMEOUT_DEF = 63;

endpackage

// File: rtl/sram_arb_pick.sv
// Request picker for the SRAM arbiter.
// A port is eligible when it requests and is not being acked this cycle, so a
// master that is just retiring a transaction is not granted again by mistake.
// On a tie, either port 0 always wins (PRIO_P0 != 0) or the port that was not
// served last wins (round robin). The last-served pointer advances only when
// take_i says the grant is actually consumed.
// Ports:
//   CLK0, reset_n   : clock, synchronous active-low reset
//   valid_i[1:0]    : per-port request
//   ack_i[1:0]      : per-port ack currently being driven
//   take_i          : the sequencer accepts a grant this cycle
//   grant_valid_o   : at least one port is eligible
//   grant_id_o      : winning port id
module sram_arb_pick
  import sram_arb_pkg::*;
#(
  parameter int PRIO_P0 = 0
) (
  input  logic       CLK0,
  input  logic       reset_n,
  input  logic [1:0] valid_i,
  input  logic [1:0] ack_i,
  input  logic       take_i,
  output logic       grant_valid_o,
  output logic       grant_id_o
);

  logic       last_q;
  logic       last_d;
  logic [1:0] elig;

  always_comb begin
    elig          = valid_i & ~ack_i;
    grant_valid_o = |elig;
    grant_id_o    = P0;
    if (elig == 2'b11) begin
      grant_id_o = (PRIO_P0 != 0) ? P0 : ~last_q;
    end else if (elig[1]) begin
      grant_id_o = P1;
    end
    last_d = last_q;
    if (take_i && grant_valid_o) begin
      last_d = grant_id_o;
    end
  end

  // Pointer resets to port 1 so that port 0 wins the first tie.
  always_ff @(posedge CLK0) begin
    if (!reset_n) begin
      last_q <= P1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter/sequencer in front of the async SRAM controller.
// Port 0 (CPU) and port 1 (DMA/video) requests are serialised: one strobe is
// issued per transaction, the controller's ready pulse is awaited, and an ack
// (plus read data) is returned to the winning port. A watchdog aborts a
// transaction whose ready never arrives.
//
// Handshake: a master raises pN_valid with pN_we/pN_addr/pN_wdata stable and
// keeps them so until pN_ack (one-cycle pulse). pN_err qualifies pN_ack as a
// timeout. Dropping valid after the grant does not cancel the transaction.
// Towards the controller, mem_rd/mem_wr are one-cycle strobes; mem_ready is a
// one-cycle completion pulse, honoured only in WAIT, with mem_rdata valid
// alongside it. At most one controller transaction is outstanding.
//
// Ports:
//   CLK0, reset_n              : clock, synchronous active-low reset
//   pN_valid/we/addr/wdata     : port N request
//   pN_ack/err/rdata           : port N completion and read data
//   mem_addr/wdata/rd/wr       : controller request (held when idle)
//   mem_rdata/mem_ready        : controller response
//   busy                       : sequencer not idle
//   grant                      : port owning current/last transaction
//   dbg_state_o                : sequencer state for observation
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int AW      = 18,
  parameter int DW      = 16,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int PRIO_P0 = 0
) (
  input  logic          CLK0,
  input  logic          reset_n,
  input  logic          p0_valid,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic          p0_err,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_valid,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic          p1_err,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy,
  output logic          grant,
  output state_t        dbg_state_o
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            we_q, we_d;
  logic            grant_q, grant_d;
  logic [1:0]      ack_q, ack_d;
  logic [1:0]      err_q, err_d;
  logic [DW-1:0]   rdata0_q, rdata0_d;
  logic [DW-1:0]   rdata1_q, rdata1_d;

  logic            pick_valid;
  logic            pick_id;

  sram_arb_pick #(
    .PRIO_P0(PRIO_P0)
  ) u_pick (
    .CLK0         (CLK0),
    .reset_n      (reset_n),
    .valid_i      ({p1_valid, p0_valid}),
    .ack_i        (ack_q),
    .take_i       (state_q == IDLE),
    .grant_valid_o(pick_valid),
    .grant_id_o   (pick_id)
  );

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    grant_d  = grant_q;
    ack_d    = 2'b00;
    err_d    = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_id;
          addr_d  = (pick_id == P1) ? p1_addr  : p0_addr;
          wdata_d = (pick_id == P1) ? p1_wdata : p0_wdata;
          we_d    = (pick_id == P1) ? p1_we    : p0_we;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // mem_ready here is deliberately ignored.
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // timer_q counts WAIT cycles already spent without ready; ready is
        // accepted on any of the TIMEOUT WAIT cycles, and the last one without
        // it aborts the transaction.
        if (mem_ready) begin
          if (!we_q) begin
            if (grant_q == P1) rdata1_d = mem_rdata;
            else               rdata0_d = mem_rdata;
          end
          ack_d[grant_q] = 1'b1;
          state_d        = IDLE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          ack_d[grant_q] = 1'b1;
          err_d[grant_q] = 1'b1;
          state_d        = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK0) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      grant_q  <= P0;
      ack_q    <= 2'b00;
      err_q    <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_rd      = (state_q == ISSUE) && !we_q;
  assign mem_wr      = (state_q == ISSUE) &&  we_q;
  assign p0_ack      = ack_q[0];
  assign p1_ack      = ack_q[1];
  assign p0_err      = err_q[0];
  assign p1_err      = err_q[1];
  assign p0_rdata    = rdata0_q;
  assign p1_rdata    = rdata1_q;
  assign busy        = (state_q != IDLE);
  assign grant       = grant_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: two instances (round robin and port-0 priority)
// driven by random masters and a random controller, compared cycle by cycle
// against a transaction-level prediction built from the arbitration rules and
// the latency formula ack = strobe + min(delay, TIMEOUT) + 1.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int AW   = 18;
  localparam int DW   = 16;
  localparam int TO   = 63;
  localparam int NCYC = 3000;

  // ---------------- clock / reset ----------------
  logic CLK0 = 1'b0;
  always #5 CLK0 = ~CLK0;

  logic          reset_n   [2];
  logic          p_valid   [2][2];
  logic          p_we      [2][2];
  logic [AW-1:0] p_addr    [2][2];
  logic [DW-1:0] p_wdata   [2][2];
  logic          p_ack     [2][2];
  logic          p_err     [2][2];
  logic [DW-1:0] p_rdata   [2][2];
  logic [AW-1:0] mem_addr  [2];
  logic [DW-1:0] mem_wdata [2];
  logic          mem_rd    [2];
  logic          mem_wr    [2];
  logic [DW-1:0] mem_rdata [2];
  logic          mem_ready [2];
  logic          busy      [2];
  logic          grant     [2];
  state_t        dbg       [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO), .PRIO_P0(g)) u_dut (
      .CLK0(CLK0), .reset_n(reset_n[g]),
      .p0_valid(p_valid[g][0]), .p0_we(p_we[g][0]), .p0_addr(p_addr[g][0]),
      .p0_wdata(p_wdata[g][0]), .p0_ack(p_ack[g][0]), .p0_err(p_err[g][0]),
      .p0_rdata(p_rdata[g][0]),
      .p1_valid(p_valid[g][1]), .p1_we(p_we[g][1]), .p1_addr(p_addr[g][1]),
      .p1_wdata(p_wdata[g][1]), .p1_ack(p_ack[g][1]), .p1_err(p_err[g][1]),
      .p1_rdata(p_rdata[g][1]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_rd(mem_rd[g]),
      .mem_wr(mem_wr[g]), .mem_rdata(mem_rdata[g]), .mem_ready(mem_ready[g]),
      .busy(busy[g]), .grant(grant[g]), .dbg_state_o(dbg[g])
    );
  end

  // ---------------- scoreboard / checker ----------------
  int total = 0;
  int bad   = 0;
  int cur_i = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL inst%0d cyc%0d %s: got=%0h want=%0h", cur_i, cyc, tag, got, exp);
    end
  endtask

  // expected outputs for the current cycle
  logic          e_busy [2], e_grant [2], e_rd [2], e_wr [2];
  logic [AW-1:0] e_addr [2];
  logic [DW-1:0] e_wdata[2];
  logic          e_ack  [2][2], e_err [2][2];
  logic [DW-1:0] e_rdata[2][2];
  // transaction in flight
  bit            t_active[2], t_port[2], t_we[2], t_err[2], r_spur[2];
  logic [DW-1:0] t_rdv[2];
  int            t_ack[2], r_ready_cyc[2], txn_cnt[2];
  bit            m_last[2];
  bit            rst_done[2];
  // masters: 0 = idle (gap countdown), 1 = requesting, 2 = granted
  int            ms[2][2], gap[2][2];
  bit            first_done[2][2];
  int            n_timeouts = 0;

  task automatic new_req(input int i, input int k);
    ms[i][k]      = 1;
    p_valid[i][k] = 1'b1;
    if (!first_done[i][k]) begin
      first_done[i][k] = 1'b1;
      p_we[i][k]    = (k == 1);
      p_addr[i][k]  = (k == 0) ? 18'h00123 : 18'h3FFFF;
      p_wdata[i][k] = (k == 0) ? 16'h0000  : 16'h00A5;
    end else begin
      p_we[i][k]    = 1'($urandom_range(1));
      p_addr[i][k]  = AW'($urandom);
      p_wdata[i][k] = DW'($urandom);
    end
  endtask

  task automatic drive_master(input int i, input int k, input bit rst, input int c);
    if (rst) begin
      p_valid[i][k] = 1'b0;
      ms[i][k]      = 0;
      if (c >= 2) gap[i][k] = 100;   // both ports restart together: first tie after reset
    end else begin
      case (ms[i][k])
        2: begin
          if (e_ack[i][k]) begin
            if ($urandom_range(3) != 0) new_req(i, k);
            else begin
              p_valid[i][k] = 1'b0;
              ms[i][k]      = 0;
              gap[i][k]     = $urandom_range(1, 5);
            end
          end else if ($urandom_range(15) == 0) begin
            p_valid[i][k] = 1'b0;      // dropping valid must not cancel
          end
        end
        1: ;
        default: begin
          if (gap[i][k] == 0) new_req(i, k);
          else gap[i][k]--;
        end
      endcase
    end
  endtask

  initial begin
    bit rst, idle_c, el0, el1, w;
    bit ack_c[2];
    int d;
    for (int i = 0; i < 2; i++) begin
      reset_n[i] = 1'b0; mem_ready[i] = 1'b0; mem_rdata[i] = '0;
      e_busy[i] = 0; e_grant[i] = 0; e_rd[i] = 0; e_wr[i] = 0;
      e_addr[i] = '0; e_wdata[i] = '0;
      t_active[i] = 0; r_ready_cyc[i] = -1; txn_cnt[i] = 0; m_last[i] = 1;
      rst_done[i] = 0; t_rdv[i] = '0; r_spur[i] = 0;
      for (int k = 0; k < 2; k++) begin
        p_valid[i][k] = 0; p_we[i][k] = 0; p_addr[i][k] = '0; p_wdata[i][k] = '0;
        e_ack[i][k] = 0; e_err[i][k] = 0; e_rdata[i][k] = '0;
        ms[i][k] = 0; first_done[i][k] = 0;
        gap[i][k] = (k == 0) ? 1 : 20;
      end
    end

    for (int c = 0; c < NCYC; c++) begin
      @(negedge CLK0);
      cyc = c;
      for (int i = 0; i < 2; i++) begin
        cur_i = i;
        // ---- compare this cycle ----
        chk("busy", busy[i], e_busy[i]);
        chk("dbg_idle", (dbg[i] == IDLE), !e_busy[i]);
        chk("grant", grant[i], e_grant[i]);
        chk("mem_addr", mem_addr[i], e_addr[i]);
        chk("mem_wdata", mem_wdata[i], e_wdata[i]);
        chk("mem_rd", mem_rd[i], e_rd[i]);
        chk("mem_wr", mem_wr[i], e_wr[i]);
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("p%0d_ack", k), p_ack[i][k], e_ack[i][k]);
          chk($sformatf("p%0d_err", k), p_err[i][k], e_err[i][k]);
          chk($sformatf("p%0d_rdata", k), p_rdata[i][k], e_rdata[i][k]);
          if (p_ack[i][k] && p_err[i][k]) n_timeouts++;
        end

        // ---- drive this cycle ----
        rst = (c < 2);
        if (!rst_done[i] && c >= 1500 && t_active[i] && (c > t_ack[i] - 5)
            && (c < t_ack[i] - 1)) begin
          rst = 1; rst_done[i] = 1;
          if (r_ready_cyc[i] <= c) r_ready_cyc[i] = c + 2;  // late ready after reset
        end
        reset_n[i] = !rst;
        for (int k = 0; k < 2; k++) drive_master(i, k, rst, c);
        mem_ready[i] = (r_ready_cyc[i] == c) ||
                       (r_spur[i] && t_active[i] && (t_ack[i] > c) && (c == t_ack[i] - 1 - 64 + 64 && 0));
        // spurious pulse during ISSUE (strobe cycle), which must be ignored
        if (r_spur[i] && t_active[i] && e_rd[i] | e_wr[i]) mem_ready[i] = 1'b1;
        mem_rdata[i] = (r_ready_cyc[i] == c) ? t_rdv[i] : DW'($urandom);

        // ---- predict next cycle ----
        idle_c   = !e_busy[i];
        ack_c[0] = e_ack[i][0];
        ack_c[1] = e_ack[i][1];
        for (int k = 0; k < 2; k++) begin e_ack[i][k] = 0; e_err[i][k] = 0; end
        e_rd[i] = 0; e_wr[i] = 0;
        if (rst) begin
          e_busy[i] = 0; e_grant[i] = 0; e_addr[i] = '0; e_wdata[i] = '0;
          e_rdata[i][0] = '0; e_rdata[i][1] = '0;
          t_active[i] = 0; m_last[i] = 1;
        end else begin
          if (t_active[i] && (c + 1 == t_ack[i])) begin
            e_ack[i][t_port[i]] = 1;
            e_err[i][t_port[i]] = t_err[i];
            if (!t_we[i] && !t_err[i]) e_rdata[i][t_port[i]] = t_rdv[i];
            t_active[i] = 0;
            e_busy[i]   = 0;
          end
          if (idle_c) begin
            el0 = p_valid[i][0] && !ack_c[0];
            el1 = p_valid[i][1] && !ack_c[1];
            if (el0 || el1) begin
              if (el0 && el1) w = (i == 1) ? 1'b0 : !m_last[i];
              else            w = el1;
              m_last[i]   = w;
              ms[i][w]    = 2;
              t_active[i] = 1; t_port[i] = w; t_we[i] = p_we[i][w];
              e_grant[i]  = w; e_busy[i] = 1;
              e_addr[i]   = p_addr[i][w]; e_wdata[i] = p_wdata[i][w];
              e_rd[i]     = !t_we[i]; e_wr[i] = t_we[i];
              // controller behaviour for this transaction
              t_rdv[i] = DW'($urandom);
              if (txn_cnt[i] == 0)      begin d = 2; t_rdv[i] = 16'hBEEF; end
              else if (txn_cnt[i] == 3) d = TO + 1;
              else if (txn_cnt[i] == 5) d = TO;
              else begin
                case ($urandom_range(15))
                  0:       d = TO + 1;
                  1:       d = $urandom_range(50, TO);
                  default: d = $urandom_range(1, 6);
                endcase
              end
              t_err[i]       = (d > TO);
              t_ack[i]       = t_err[i] ? (c + 1 + TO + 1) : (c + 1 + d + 1);
              r_ready_cyc[i] = t_err[i] ? -1 : (c + 1 + d);
              r_spur[i]      = ($urandom_range(7) == 0);
              txn_cnt[i]++;
            end
          end
        end
      end
    end

    cur_i = 2;
    chk("timeouts_seen", (n_timeouts >= 2), 1);
    chk("resets_mid_wait", {30'd0, rst_done[1], rst_done[0]}, 32'd3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
